// File: rtl/writeback_multi_pkg.sv
// Shared types for the multi-lane writeback stage:
// per-lane input bundle, commit record and drain FSM state.
package writeback_multi_pkg;

   localparam int XLEN = 64;
   localparam int RA_W = 5;
   localparam int CA_W = 12;

   typedef struct packed {
      logic            valid;
      logic            wb;
      logic            mrd;
      logic            jmp;
      logic            ismem;
      logic            csr_we;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] mem;
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] maddr;
      logic [31:0]     instr;
      logic [CA_W-1:0] csr_addr;
      logic [XLEN-1:0] csr_data;
   } wb_lane_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            is_wb;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] wdata;
      logic            is_mem;
      logic [XLEN-1:0] maddr;
   } commit_t;

   typedef enum logic {
      IDLE,
      CSR_DRAIN
   } wb_state_t;

   // Load data beats link address, which beats the ALU result.
   function automatic logic [XLEN-1:0] lane_result(input wb_lane_t l);
      if (l.mrd)
         return l.mem;
      else if (l.jmp)
         return l.pc4;
      else
         return l.alu;
   endfunction

endpackage

// File: rtl/wb_commit_fifo.sv
// Commit record FIFO: up to NLANE pushes per cycle in lane
// order, one pop per cycle, registered free-entry count.
module wb_commit_fifo
   import writeback_multi_pkg::*;
#(
   parameter int CQ_DEPTH = 8,
   parameter int NLANE    = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NLANE-1:0]               push,
   input  commit_t [NLANE-1:0]            push_rec,
   input  logic                           pop,
   output logic                           valid,
   output commit_t                        head,
   output logic [$clog2(CQ_DEPTH+1)-1:0]  free
);

   localparam int PW = $clog2(CQ_DEPTH);
   localparam int CW = $clog2(CQ_DEPTH + 1);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] free_q;
   logic [CW-1:0] n_push;
   logic [PW-1:0] slot [NLANE];
   logic          pop_ok;
   commit_t       mem [CQ_DEPTH];

   assign valid  = (count != '0);
   assign pop_ok = pop & valid;
   assign free   = free_q;
   assign head   = valid ? mem[rd_ptr] : '0;

   // Compact pushing lanes into consecutive slots.
   always_comb begin
      n_push = '0;
      for (int i = 0; i < NLANE; i++) begin
         slot[i] = wr_ptr + n_push[PW-1:0];
         n_push  = n_push + CW'(push[i]);
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         free_q <= CW'(CQ_DEPTH);
      end else begin
         wr_ptr <= wr_ptr + n_push[PW-1:0];
         if (pop_ok)
            rd_ptr <= rd_ptr + PW'(1);
         count  <= count + n_push - CW'(pop_ok);
         free_q <= free_q - n_push + CW'(pop_ok);
      end
   end

   // Record storage; head is masked while empty.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NLANE; i++)
         if (push[i])
            mem[slot[i]] <= push_rec[i];
   end

endmodule

// File: rtl/writeback_multi.sv
// N-lane writeback/commit stage: GPR write ports with WAW
// masking, serialised CSR port and buffered commit records.
module writeback_multi
   import writeback_multi_pkg::*;
#(
   parameter int NLANE    = 2,
   parameter int CQ_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_bvalid,
   output logic                    in_ready,
   input  logic [NLANE-1:0]        in_lvalid,
   input  logic [NLANE-1:0]        in_wb,
   input  logic [NLANE-1:0]        in_mrd,
   input  logic [NLANE-1:0]        in_jmp,
   input  logic [NLANE*RA_W-1:0]   in_rd,
   input  logic [NLANE*XLEN-1:0]   in_alu,
   input  logic [NLANE*XLEN-1:0]   in_mem,
   input  logic [NLANE*XLEN-1:0]   in_pc4,
   input  logic [NLANE*XLEN-1:0]   in_pc,
   input  logic [NLANE*XLEN-1:0]   in_maddr,
   input  logic [NLANE*32-1:0]     in_instr,
   input  logic [NLANE-1:0]        in_ismem,
   input  logic [NLANE-1:0]        in_csr_we,
   input  logic [NLANE*CA_W-1:0]   in_csr_addr,
   input  logic [NLANE*XLEN-1:0]   in_csr_data,
   output logic [NLANE-1:0]        gpr_we,
   output logic [NLANE*RA_W-1:0]   gpr_wd,
   output logic [NLANE*XLEN-1:0]   gpr_wdata,
   output logic                    csr_we,
   output logic [CA_W-1:0]         csr_addr,
   output logic [XLEN-1:0]         csr_data,
   output logic                    cm_valid,
   input  logic                    cm_ready,
   output commit_t                 cm_rec
);

   localparam int CW = $clog2(CQ_DEPTH + 1);

   wb_lane_t [NLANE-1:0] lane;
   commit_t  [NLANE-1:0] rec;
   logic [XLEN-1:0]      res [NLANE];
   logic [NLANE-1:0]     wr;
   logic [NLANE-1:0]     we_mask;
   logic [NLANE-1:0]     csr_req;
   logic [NLANE-1:0]     push;
   logic [CW-1:0]        free;
   logic                 accept;

   wb_state_t        state;
   wb_state_t        state_nxt;
   logic [NLANE-1:0] pend;
   logic [NLANE-1:0] pend_nxt;
   logic [NLANE-1:0] sel;
   logic [CA_W-1:0]  pend_addr [NLANE];
   logic [XLEN-1:0]  pend_data [NLANE];
   logic             csr_we_nxt;
   logic [CA_W-1:0]  csr_a_sel;
   logic [XLEN-1:0]  csr_d_sel;

   assign in_ready = (state == IDLE) & (free >= CW'(NLANE));
   assign accept   = in_bvalid & in_ready;
   assign push     = accept ? in_lvalid : '0;

   // Unpack lanes, pick results, mask older same-rd writes.
   always_comb begin
      for (int i = 0; i < NLANE; i++) begin
         lane[i].valid    = in_lvalid[i];
         lane[i].wb       = in_wb[i];
         lane[i].mrd      = in_mrd[i];
         lane[i].jmp      = in_jmp[i];
         lane[i].ismem    = in_ismem[i];
         lane[i].csr_we   = in_csr_we[i];
         lane[i].rd       = in_rd[i*RA_W +: RA_W];
         lane[i].alu      = in_alu[i*XLEN +: XLEN];
         lane[i].mem      = in_mem[i*XLEN +: XLEN];
         lane[i].pc4      = in_pc4[i*XLEN +: XLEN];
         lane[i].pc       = in_pc[i*XLEN +: XLEN];
         lane[i].maddr    = in_maddr[i*XLEN +: XLEN];
         lane[i].instr    = in_instr[i*32 +: 32];
         lane[i].csr_addr = in_csr_addr[i*CA_W +: CA_W];
         lane[i].csr_data = in_csr_data[i*XLEN +: XLEN];
      end
      for (int i = 0; i < NLANE; i++) begin
         res[i]     = lane_result(lane[i]);
         wr[i]      = lane[i].valid & (lane[i].wb | lane[i].jmp)
                      & (|lane[i].rd);
         csr_req[i] = lane[i].valid & lane[i].csr_we;
      end
      for (int i = 0; i < NLANE; i++) begin
         we_mask[i] = wr[i];
         for (int j = 0; j < NLANE; j++)
            if (j > i && wr[j] && lane[j].rd == lane[i].rd)
               we_mask[i] = 1'b0;
      end
   end

   // Commit records, one per lane.
   always_comb begin
      for (int i = 0; i < NLANE; i++) begin
         rec[i].pc     = lane[i].pc;
         rec[i].instr  = lane[i].instr;
         rec[i].is_wb  = wr[i];
         rec[i].rd     = lane[i].rd;
         rec[i].wdata  = res[i];
         rec[i].is_mem = lane[i].ismem;
         rec[i].maddr  = lane[i].maddr;
      end
   end

   wb_commit_fifo #(
      .CQ_DEPTH (CQ_DEPTH),
      .NLANE    (NLANE)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_rec (rec),
      .pop      (cm_ready),
      .valid    (cm_valid),
      .head     (cm_rec),
      .free     (free)
   );

   // GPR write ports, live one cycle after accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpr_we    <= '0;
         gpr_wd    <= '0;
         gpr_wdata <= '0;
      end else if (accept) begin
         gpr_we <= we_mask;
         for (int i = 0; i < NLANE; i++) begin
            gpr_wd[i*RA_W +: RA_W]    <= lane[i].rd;
            gpr_wdata[i*XLEN +: XLEN] <= res[i];
         end
      end else begin
         gpr_we <= '0;
      end
   end

   // Drain FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and lowest-lane CSR write selection.
   always_comb begin
      state_nxt  = state;
      pend_nxt   = pend;
      csr_we_nxt = 1'b0;
      sel        = '0;
      csr_a_sel  = '0;
      csr_d_sel  = '0;
      unique case (state)
         IDLE: begin
            pend_nxt = '0;
            if (accept && |csr_req) begin
               csr_we_nxt = 1'b1;
               sel        = csr_req;
               pend_nxt   = csr_req & (csr_req - NLANE'(1));
               if (|pend_nxt)
                  state_nxt = CSR_DRAIN;
            end
         end
         CSR_DRAIN: begin
            if (|pend) begin
               csr_we_nxt = 1'b1;
               sel        = pend;
               pend_nxt   = pend & (pend - NLANE'(1));
            end else begin
               state_nxt = IDLE;
            end
         end
      endcase
      for (int i = NLANE - 1; i >= 0; i--) begin
         if (sel[i]) begin
            csr_a_sel = (state == IDLE) ? lane[i].csr_addr
                                        : pend_addr[i];
            csr_d_sel = (state == IDLE) ? lane[i].csr_data
                                        : pend_data[i];
         end
      end
   end

   // CSR output port and pending-write store.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csr_we   <= 1'b0;
         csr_addr <= '0;
         csr_data <= '0;
         pend     <= '0;
         for (int i = 0; i < NLANE; i++) begin
            pend_addr[i] <= '0;
            pend_data[i] <= '0;
         end
      end else begin
         csr_we <= csr_we_nxt;
         pend   <= pend_nxt;
         if (csr_we_nxt) begin
            csr_addr <= csr_a_sel;
            csr_data <= csr_d_sel;
         end
         if (accept) begin
            for (int i = 0; i < NLANE; i++) begin
               pend_addr[i] <= lane[i].csr_addr;
               pend_data[i] <= lane[i].csr_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_writeback_multi.sv
// Bench for writeback_multi: directed bundles plus random
// traffic against a queue-based behavioural model.
module tb_writeback_multi;
   import writeback_multi_pkg::*;

   localparam int NL    = 2;
   localparam int DEPTH = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_bvalid;
   logic                 in_ready;
   logic [NL-1:0]        in_lvalid, in_wb, in_mrd, in_jmp;
   logic [NL*RA_W-1:0]   in_rd;
   logic [NL*XLEN-1:0]   in_alu, in_mem, in_pc4, in_pc, in_maddr;
   logic [NL*32-1:0]     in_instr;
   logic [NL-1:0]        in_ismem, in_csr_we;
   logic [NL*CA_W-1:0]   in_csr_addr;
   logic [NL*XLEN-1:0]   in_csr_data;
   logic [NL-1:0]        gpr_we;
   logic [NL*RA_W-1:0]   gpr_wd;
   logic [NL*XLEN-1:0]   gpr_wdata;
   logic                 csr_we;
   logic [CA_W-1:0]      csr_addr;
   logic [XLEN-1:0]      csr_data;
   logic                 cm_valid;
   logic                 cm_ready;
   commit_t              cm_rec;

   writeback_multi #(.NLANE(NL), .CQ_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_bvalid(in_bvalid), .in_ready(in_ready),
      .in_lvalid(in_lvalid), .in_wb(in_wb),
      .in_mrd(in_mrd), .in_jmp(in_jmp), .in_rd(in_rd),
      .in_alu(in_alu), .in_mem(in_mem), .in_pc4(in_pc4),
      .in_pc(in_pc), .in_maddr(in_maddr),
      .in_instr(in_instr), .in_ismem(in_ismem),
      .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr),
      .in_csr_data(in_csr_data),
      .gpr_we(gpr_we), .gpr_wd(gpr_wd),
      .gpr_wdata(gpr_wdata),
      .csr_we(csr_we), .csr_addr(csr_addr),
      .csr_data(csr_data),
      .cm_valid(cm_valid), .cm_ready(cm_ready),
      .cm_rec(cm_rec)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag,
                      input logic [255:0] got,
                      input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [CA_W-1:0] a;
      logic [XLEN-1:0] d;
   } csrw_t;

   commit_t         mq[$];
   csrw_t           cq[$];
   csrw_t           cur_csr;
   bit              cur_csr_v;
   int              busy;
   logic [NL-1:0]   e_gwe;
   logic [RA_W-1:0] e_gwd [NL];
   logic [XLEN-1:0] e_gwdata [NL];

   function automatic bit exp_ready();
      return busy == 0 && (DEPTH - mq.size()) >= NL;
   endfunction

   task automatic model_reset();
      mq.delete();
      cq.delete();
      cur_csr_v = 0;
      busy      = 0;
      e_gwe     = '0;
   endtask

   // Advance the model across one rising edge.
   task automatic model_edge();
      bit              acc;
      bit              wr [NL];
      logic [XLEN-1:0] res [NL];
      int              k;
      commit_t         r;
      csrw_t           w;
      acc = in_bvalid && exp_ready();
      k   = 0;
      if (cm_ready && mq.size() > 0)
         void'(mq.pop_front());
      e_gwe = '0;
      if (acc) begin
         for (int i = 0; i < NL; i++) begin
            if (in_mrd[i])      res[i] = in_mem[i*XLEN +: XLEN];
            else if (in_jmp[i]) res[i] = in_pc4[i*XLEN +: XLEN];
            else                res[i] = in_alu[i*XLEN +: XLEN];
            wr[i] = in_lvalid[i] && (in_wb[i] || in_jmp[i])
                    && in_rd[i*RA_W +: RA_W] != 0;
         end
         for (int i = 0; i < NL; i++) begin
            e_gwe[i] = wr[i];
            for (int j = i + 1; j < NL; j++)
               if (wr[j] && in_rd[j*RA_W +: RA_W]
                            == in_rd[i*RA_W +: RA_W])
                  e_gwe[i] = 1'b0;
            e_gwd[i]    = in_rd[i*RA_W +: RA_W];
            e_gwdata[i] = res[i];
         end
         for (int i = 0; i < NL; i++) begin
            if (in_lvalid[i]) begin
               r.pc     = in_pc[i*XLEN +: XLEN];
               r.instr  = in_instr[i*32 +: 32];
               r.is_wb  = wr[i];
               r.rd     = in_rd[i*RA_W +: RA_W];
               r.wdata  = res[i];
               r.is_mem = in_ismem[i];
               r.maddr  = in_maddr[i*XLEN +: XLEN];
               mq.push_back(r);
               if (in_csr_we[i]) begin
                  w.a = in_csr_addr[i*CA_W +: CA_W];
                  w.d = in_csr_data[i*XLEN +: XLEN];
                  cq.push_back(w);
                  k++;
               end
            end
         end
      end
      if (busy > 0) busy--;
      if (acc && k > 1) busy = k;
      cur_csr_v = cq.size() > 0;
      if (cur_csr_v) cur_csr = cq.pop_front();
   endtask

   task automatic check_outputs();
      chk("in_ready", in_ready, exp_ready());
      chk("gpr_we", gpr_we, e_gwe);
      for (int i = 0; i < NL; i++) begin
         if (e_gwe[i]) begin
            chk("gpr_wd", gpr_wd[i*RA_W +: RA_W], e_gwd[i]);
            chk("gpr_wdata", gpr_wdata[i*XLEN +: XLEN],
                e_gwdata[i]);
         end
      end
      chk("csr_we", csr_we, cur_csr_v);
      if (cur_csr_v) begin
         chk("csr_addr", csr_addr, cur_csr.a);
         chk("csr_data", csr_data, cur_csr.d);
      end
      chk("cm_valid", cm_valid, mq.size() > 0);
      if (mq.size() > 0)
         chk("cm_rec", cm_rec, mq[0]);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic clear_in();
      in_bvalid   = 0;
      in_lvalid   = '0;
      in_wb       = '0;
      in_mrd      = '0;
      in_jmp      = '0;
      in_rd       = '0;
      in_alu      = '0;
      in_mem      = '0;
      in_pc4      = '0;
      in_pc       = '0;
      in_maddr    = '0;
      in_instr    = '0;
      in_ismem    = '0;
      in_csr_we   = '0;
      in_csr_addr = '0;
      in_csr_data = '0;
   endtask

   task automatic set_lane(input int i, input bit wb, input bit mrd,
                           input bit jmp, input logic [RA_W-1:0] rd,
                           input logic [XLEN-1:0] alu,
                           input logic [XLEN-1:0] mem,
                           input logic [XLEN-1:0] pc);
      in_lvalid[i]               = 1'b1;
      in_wb[i]                   = wb;
      in_mrd[i]                  = mrd;
      in_jmp[i]                  = jmp;
      in_ismem[i]                = mrd;
      in_rd[i*RA_W +: RA_W]      = rd;
      in_alu[i*XLEN +: XLEN]     = alu;
      in_mem[i*XLEN +: XLEN]     = mem;
      in_pc[i*XLEN +: XLEN]      = pc;
      in_pc4[i*XLEN +: XLEN]     = pc + 64'd4;
      in_maddr[i*XLEN +: XLEN]   = alu;
      in_instr[i*32 +: 32]       = pc[31:0] ^ 32'h13;
   endtask

   task automatic set_csr(input int i, input logic [CA_W-1:0] a,
                          input logic [XLEN-1:0] d);
      in_csr_we[i]                = 1'b1;
      in_csr_addr[i*CA_W +: CA_W] = a;
      in_csr_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic rand_lanes();
      logic [XLEN-1:0] pc;
      clear_in();
      in_bvalid = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NL; i++) begin
         pc = {32'h0, $urandom} & ~64'h3;
         if ($urandom_range(0, 3) != 0)
            set_lane(i, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0,
                     RA_W'($urandom_range(0, 7)),
                     {$urandom, $urandom},
                     {$urandom, $urandom}, pc);
         in_ismem[i] = in_ismem[i] | ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 3) == 0)
            set_csr(i, CA_W'($urandom), {$urandom, $urandom});
      end
      cm_ready = ($urandom_range(0, 9) < 6);
   endtask

   task automatic do_reset();
      clear_in();
      cm_ready = 0;
      rst = 1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   initial begin
      clear_in();
      cm_ready = 0;
      rst = 0;
      @(negedge clk);
      do_reset();
      #1;
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_gpr_we", gpr_we, '0);
      chk("rst_csr_we", csr_we, 1'b0);
      chk("rst_cm_valid", cm_valid, 1'b0);
      chk("rst_gpr_wdata", gpr_wdata, '0);
      chk("rst_csr_data", csr_data, '0);
      step();

      // two lanes: ALU result and load result
      set_lane(0, 1, 0, 0, 5, 64'h11, 64'h0, 64'h1000);
      set_lane(1, 1, 1, 0, 6, 64'h99, 64'h22, 64'h1004);
      in_bvalid = 1;
      step();
      chk("b1_we", gpr_we, 2'b11);
      chk("b1_wd0", gpr_wdata[63:0], 64'h11);
      chk("b1_wd1", gpr_wdata[127:64], 64'h22);
      clear_in();
      cm_ready = 1;
      chk("b1_pc0", cm_rec.pc, 64'h1000);
      step();
      chk("b1_pc1", cm_rec.pc, 64'h1004);
      step();
      step();

      // same rd in both lanes, lane 1 is a jump
      set_lane(0, 1, 0, 0, 7, 64'h1, 64'h0, 64'h80000000);
      set_lane(1, 0, 0, 1, 7, 64'h5, 64'h0, 64'h80000004);
      in_bvalid = 1;
      step();
      chk("waw_we", gpr_we, 2'b10);
      chk("waw_wd", gpr_wdata[127:64], 64'h80000008);
      clear_in();
      step();

      // two CSR writes in one bundle
      set_lane(0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h2000);
      set_lane(1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h2004);
      set_csr(0, 12'h300, 64'hAA);
      set_csr(1, 12'h305, 64'hBB);
      in_bvalid = 1;
      step();
      chk("csr0_addr", csr_addr, 12'h300);
      chk("csr0_rdy", in_ready, 1'b0);
      clear_in();
      step();
      chk("csr1_addr", csr_addr, 12'h305);
      chk("csr1_rdy", in_ready, 1'b0);
      step();
      chk("csr_done_rdy", in_ready, 1'b1);
      repeat (2) step();

      // fill the FIFO with consumer stalled
      cm_ready = 0;
      for (int b = 0; b < 4; b++) begin
         clear_in();
         set_lane(0, 1, 0, 0, 1, 64'(b), 64'h0, 64'(b * 8));
         set_lane(1, 1, 0, 0, 2, 64'(b), 64'h0, 64'(b * 8 + 4));
         in_bvalid = 1;
         step();
      end
      chk("full_rdy", in_ready, 1'b0);
      clear_in();
      cm_ready = 1;
      step();
      chk("pop1_rdy", in_ready, 1'b0);
      step();
      chk("pop2_rdy", in_ready, 1'b1);
      repeat (8) step();

      // rd=0 with wb: no write, record still pushed
      cm_ready = 0;
      set_lane(0, 1, 0, 0, 0, 64'h33, 64'h0, 64'h3000);
      in_bvalid = 1;
      step();
      chk("rd0_we", gpr_we, 2'b00);
      chk("rd0_iswb", cm_rec.is_wb, 1'b0);
      chk("rd0_pc", cm_rec.pc, 64'h3000);
      clear_in();
      cm_ready = 1;
      repeat (2) step();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         rand_lanes();
         step();
      end
      clear_in();
      cm_ready = 1;
      repeat (10) step();

      // reset in the middle of a CSR drain
      cm_ready = 0;
      set_lane(0, 1, 0, 0, 3, 64'h7, 64'h0, 64'h4000);
      set_lane(1, 1, 0, 0, 4, 64'h8, 64'h0, 64'h4004);
      set_csr(0, 12'h340, 64'h1);
      set_csr(1, 12'h341, 64'h2);
      in_bvalid = 1;
      step();
      chk("drain_state", in_ready, 1'b0);
      clear_in();
      rst = 1;
      model_reset();
      #1;
      chk("mid_rst_csr_we", csr_we, 1'b0);
      chk("mid_rst_cm_valid", cm_valid, 1'b0);
      chk("mid_rst_gpr_we", gpr_we, '0);
      @(negedge clk);
      rst = 0;
      #1;
      chk("post_rst_ready", in_ready, 1'b1);
      @(negedge clk);
      check_outputs();
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
